exc_ctrl: RTL and testbench

Exception/interrupt sequencer and CP0 register bank for the MIPS core. It sits beside the datapath, takes the ALU trap flag, external interrupt lines and ERET/MTC0/MFC0 decode strobes, and holds the Status, Cause and EPC registers. On an exception it stalls and flushes the pipeline, then steers the PC to the handler vector. On ERET it returns the PC to EPC. It drives EXL/IV back into the main decoder.

---
 rtl/exc_ctrl.sv | 150 +++++++++++++++
 tb/tb_exc_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer with CP0 Status/Cause/EPC; trap at edge E -> flush E+1, vector PC E+2.
// No handshake: stall/flush/pc_sel are registered and decoded from the state; MFC0 reads are combinational.
module exc_ctrl #(
    parameter int               wide    = 32,
    parameter logic [wide-1:0]  exc_vec = 32'h0000_0180
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [wide-1:0] pc_cur,
    input  logic            trap,
    input  logic [5:0]      int_req,
    input  logic            eret,
    input  logic            we_cp0,
    input  logic [4:0]      cp0_a,
    input  logic [wide-1:0] cp0_wd,
    output logic [wide-1:0] cp0_rd,
    output logic            stall,
    output logic            flush,
    output logic            pc_sel,
    output logic [wide-1:0] pc_target,
    output logic            exl,
    output logic            iv
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_VECTOR, S_ERET} state_t;

    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] EC_INT   = 5'd0;
    localparam logic [4:0] EC_TR    = 5'd13;

    state_t          state_q;
    logic [7:0]      im_q;
    logic            exl_q;
    logic            ie_q;
    logic            iv_q;
    logic [5:0]      ip_q;
    logic [4:0]      exc_code_q;
    logic [wide-1:0] epc_q;
    logic            stall_q;
    logic            flush_q;
    logic            pc_sel_q;
    logic [wide-1:0] pc_target_q;

    logic            int_pend_d;
    logic            take_exc_d;
    logic            eret_go_d;
    logic [wide-1:0] status_d;
    logic [wide-1:0] cause_d;

    assign int_pend_d = ie_q & ~exl_q & (|(int_req & im_q[5:0]));
    assign take_exc_d = trap | (int_pend_d & ~eret);
    assign eret_go_d  = eret & exl_q;

    assign status_d = {{(wide-16){1'b0}}, im_q, 6'b0, exl_q, ie_q};
    assign cause_d  = {{(wide-24){1'b0}}, iv_q, 7'b0, ip_q, 3'b0, exc_code_q, 2'b0};

    always_comb begin
        cp0_rd = '0;
        case (cp0_a)
            A_STATUS: cp0_rd = status_d;
            A_CAUSE:  cp0_rd = cause_d;
            A_EPC:    cp0_rd = epc_q;
            default:  cp0_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            im_q        <= '0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            iv_q        <= 1'b0;
            ip_q        <= '0;
            exc_code_q  <= '0;
            epc_q       <= '0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            pc_sel_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            ip_q <= int_req;
            case (state_q)
                S_RUN: begin
                    stall_q     <= 1'b0;
                    flush_q     <= 1'b0;
                    pc_sel_q    <= 1'b0;
                    pc_target_q <= '0;
                    if (take_exc_d) begin
                        state_q <= S_FLUSH;
                        stall_q <= 1'b1;
                        flush_q <= 1'b1;
                        // A nested exception keeps the original return address.
                        if (!exl_q)
                            epc_q <= pc_cur;
                        exl_q      <= 1'b1;
                        exc_code_q <= trap ? EC_TR : EC_INT;
                        iv_q       <= ~trap;
                    end else begin
                        if (we_cp0) begin
                            if (cp0_a == A_STATUS) begin
                                im_q  <= cp0_wd[15:8];
                                exl_q <= cp0_wd[1];
                                ie_q  <= cp0_wd[0];
                            end else if (cp0_a == A_EPC) begin
                                epc_q <= cp0_wd;
                            end
                        end
                        if (eret_go_d) begin
                            state_q     <= S_ERET;
                            flush_q     <= 1'b1;
                            pc_sel_q    <= 1'b1;
                            pc_target_q <= epc_q;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q     <= S_VECTOR;
                    stall_q     <= 1'b0;
                    flush_q     <= 1'b0;
                    pc_sel_q    <= 1'b1;
                    pc_target_q <= exc_vec;
                end
                S_VECTOR: begin
                    state_q     <= S_RUN;
                    pc_sel_q    <= 1'b0;
                    pc_target_q <= '0;
                end
                S_ERET: begin
                    state_q     <= S_RUN;
                    flush_q     <= 1'b0;
                    pc_sel_q    <= 1'b0;
                    pc_target_q <= '0;
                    exl_q       <= 1'b0;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign stall     = stall_q;
    assign flush     = flush_q;
    assign pc_sel    = pc_sel_q;
    assign pc_target = pc_target_q;
    assign exl       = exl_q;
    assign iv        = iv_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboarded bench for exc_ctrl: a behavioural CP0 model predicts each cycle's outputs and MFC0 data.
// The driver pushes one expectation per cycle; a negedge monitor pops and compares.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        trap;
    logic [5:0]  int_req;
    logic        eret;
    logic        we_cp0;
    logic [4:0]  cp0_a;
    logic [31:0] cp0_wd;
    logic [31:0] cp0_rd;
    logic        stall;
    logic        flush;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        exl;
    logic        iv;

    exc_ctrl #(.wide(32), .exc_vec(32'h0000_0180)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .trap(trap), .int_req(int_req),
        .eret(eret), .we_cp0(we_cp0), .cp0_a(cp0_a), .cp0_wd(cp0_wd),
        .cp0_rd(cp0_rd), .stall(stall), .flush(flush), .pc_sel(pc_sel),
        .pc_target(pc_target), .exl(exl), .iv(iv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One output "beat" of the redirect sequence the controller plays out.
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        pc_sel;
        logic [31:0] tgt;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic        exl;
        logic        iv;
        logic [31:0] rd;
    } exp_t;

    localparam beat_t IDLE_B   = '{1'b0, 1'b0, 1'b0, 32'h0};
    localparam beat_t FLUSH_B  = '{1'b1, 1'b1, 1'b0, 32'h0};
    localparam beat_t VECTOR_B = '{1'b0, 1'b0, 1'b1, 32'h0000_0180};

    logic [7:0]  m_im;
    logic        m_ie, m_exl, m_iv;
    logic [5:0]  m_ip;
    int          m_code;
    logic [31:0] m_epc;
    beat_t       m_out;
    beat_t       m_beats[$];
    exp_t        sbq[$];

    function automatic void m_reset();
        m_im = 0; m_ie = 0; m_exl = 0; m_iv = 0; m_ip = 0; m_code = 0; m_epc = 0;
        m_out = IDLE_B;
        m_beats.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] status, cause;
        status = 32'(m_im) * 256 + 32'(m_exl) * 2 + 32'(m_ie);
        cause  = 32'(m_iv) * (1 << 23) + 32'(m_ip) * (1 << 10) + 32'(m_code) * 4;
        case (a)
            5'd12:   return status;
            5'd13:   return cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Applies the architectural effect of one clock edge using the inputs held before it.
    function automatic void model_edge();
        logic  busy, was_eret, pend, eret_take;
        logic [31:0] old_epc;
        beat_t nxt;
        if (!rst) begin
            m_reset();
            return;
        end
        busy     = m_out.stall | m_out.flush | m_out.pc_sel;
        was_eret = m_out.flush & m_out.pc_sel;
        pend     = m_ie && !m_exl && ((int_req & m_im[5:0]) != 0);
        nxt      = IDLE_B;
        if (busy) begin
            if (m_beats.size() > 0) nxt = m_beats.pop_front();
            if (was_eret) m_exl = 0;
        end else if (trap || (pend && !eret)) begin
            if (!m_exl) m_epc = pc_cur;
            m_exl  = 1;
            m_code = trap ? 13 : 0;
            m_iv   = !trap;
            nxt    = FLUSH_B;
            m_beats.push_back(VECTOR_B);
        end else begin
            eret_take = eret && m_exl;
            old_epc   = m_epc;
            if (we_cp0 && cp0_a == 5'd12) begin
                m_im  = cp0_wd[15:8];
                m_exl = cp0_wd[1];
                m_ie  = cp0_wd[0];
            end else if (we_cp0 && cp0_a == 5'd14) begin
                m_epc = cp0_wd;
            end
            if (eret_take) nxt = '{1'b0, 1'b1, 1'b1, old_epc};
        end
        m_ip  = int_req;
        m_out = nxt;
    endfunction

    task automatic cyc(input logic r, input logic [31:0] pc, input logic t, input logic [5:0] ir,
                       input logic e, input logic w, input logic [4:0] a, input logic [31:0] wd);
        exp_t x;
        @(posedge clk);
        model_edge();
        #1;
        rst = r; pc_cur = pc; trap = t; int_req = ir; eret = e; we_cp0 = w; cp0_a = a; cp0_wd = wd;
        if (!r) m_reset();
        x.b = m_out; x.exl = m_exl; x.iv = m_iv; x.rd = m_read(a);
        sbq.push_back(x);
        #1;
    endtask

    task automatic run(input logic t, input logic [5:0] ir, input logic e, input logic [4:0] a);
        cyc(1'b1, 32'h0000_0100, t, ir, e, 1'b0, a, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("stall",     32'(stall),  32'(e.b.stall));
            chk("flush",     32'(flush),  32'(e.b.flush));
            chk("pc_sel",    32'(pc_sel), 32'(e.b.pc_sel));
            chk("pc_target", pc_target,   e.b.tgt);
            chk("exl",       32'(exl),    32'(e.exl));
            chk("iv",        32'(iv),     32'(e.iv));
            chk("cp0_rd",    cp0_rd,      e.rd);
        end
    end

    initial begin
        rst = 0; pc_cur = 0; trap = 0; int_req = 0; eret = 0; we_cp0 = 0; cp0_a = 12; cp0_wd = 0;
        m_reset();

        // Reset, then read back all three registers.
        cyc(1'b0, 0, 0, 0, 0, 0, 5'd12, 0);
        cyc(1'b0, 0, 0, 0, 0, 0, 5'd12, 0);
        run(0, 0, 0, 5'd12);
        chk("rst_status", cp0_rd, 32'h0);
        run(0, 0, 0, 5'd13);
        chk("rst_cause", cp0_rd, 32'h0);
        run(0, 0, 0, 5'd14);
        chk("rst_epc", cp0_rd, 32'h0);
        chk("rst_ctl", {29'b0, stall, flush, pc_sel}, 32'h0);

        // Trap at pc 0x40.
        cyc(1'b1, 32'h40, 1, 0, 0, 0, 5'd14, 0);
        run(0, 0, 0, 5'd14);
        chk("trap_flush", {30'b0, stall, flush}, 32'h3);
        run(0, 0, 0, 5'd14);
        chk("trap_vec", pc_target, 32'h180);
        chk("trap_vec_sel", 32'(pc_sel), 32'h1);
        run(0, 0, 0, 5'd14);
        chk("trap_epc", cp0_rd, 32'h40);
        run(0, 0, 0, 5'd13);
        chk("trap_cause", cp0_rd, 32'h34);
        chk("trap_exl_iv", {30'b0, exl, iv}, 32'h2);

        // ERET back to 0x40, then an ERET with EXL clear does nothing.
        run(0, 0, 1, 5'd12);
        run(0, 0, 0, 5'd12);
        chk("eret_redir", {pc_target[29:0], flush, pc_sel}, {30'h40, 2'b11});
        run(0, 0, 0, 5'd12);
        chk("eret_exl", 32'(exl), 32'h0);
        run(0, 0, 1, 5'd12);
        run(0, 0, 0, 5'd12);
        chk("eret_noop", 32'(pc_sel), 32'h0);

        // Masked interrupt, then enable IM2/IE.
        run(0, 6'b000100, 0, 5'd12);
        run(0, 6'b000100, 0, 5'd12);
        chk("int_masked", 32'(stall), 32'h0);
        cyc(1'b1, 32'h88, 0, 6'b000100, 0, 1, 5'd12, 32'h0000_0401);
        cyc(1'b1, 32'h88, 0, 6'b000100, 0, 0, 5'd13, 0);
        cyc(1'b1, 32'h88, 0, 6'b000100, 0, 0, 5'd13, 0);
        chk("int_flush", 32'(flush), 32'h1);
        chk("int_cause", cp0_rd, 32'h0080_1000);
        run(0, 6'b000100, 0, 5'd14);
        run(0, 6'b000100, 0, 5'd14);
        chk("int_epc", cp0_rd, 32'h88);

        // Trap, live interrupt and Status write together right after ERET.
        run(0, 0, 1, 5'd12);
        run(0, 0, 0, 5'd12);
        cyc(1'b1, 32'h99, 1, 6'b000100, 0, 1, 5'd12, 32'h0);
        cyc(1'b1, 32'h99, 0, 6'b000100, 0, 0, 5'd13, 0);
        chk("simul_cause", cp0_rd, 32'h1034);
        run(0, 0, 0, 5'd12);
        chk("simul_status", cp0_rd, 32'h403);
        run(0, 0, 0, 5'd12);

        // Reset dropped in FLUSH.
        cyc(1'b1, 32'h123, 1, 0, 0, 0, 5'd14, 0);
        cyc(1'b0, 0, 0, 0, 0, 0, 5'd14, 0);
        chk("mid_rst", {29'b0, stall, flush, pc_sel}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            run(0, 0, 0, 5'd14);
            chk("mid_rst_nosel", 32'(pc_sel), 32'h0);
        end
        chk("mid_rst_epc", cp0_rd, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, t, e, w;
            logic [5:0]  ir;
            logic [4:0]  a;
            logic [31:0] wd;
            r  = ($urandom_range(0, 199) != 0);
            t  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 7) == 0);
            w  = ($urandom_range(0, 5) == 0);
            ir = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            case ($urandom_range(0, 3))
                0: a = 5'd12;
                1: a = 5'd13;
                2: a = 5'd14;
                default: a = 5'($urandom);
            endcase
            wd = $urandom;
            cyc(r, $urandom, t, ir, e, w, a, wd);
        end
        run(0, 0, 0, 5'd12);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
